instr_fetch_queue: RTL and testbench
====================================

Name: instr_fetch_queue

Overview:
- Fetch stage directly upstream of the 4-bit core's decode/register-file/ALU path.
- Owns the fetch PC, drives the combinational instruction memory address and captures each 12-bit instruction with its PC into a small FIFO.
- Presents instructions to decode through a valid/ready handshake, so decode can stall without losing fetched instructions.
- Supports a flush/redirect that discards queued instructions and restarts fetch at a new PC.

Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2.
- IW, 12, instruction width in bits.
- AW, 4, PC and instruction-memory address width in bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- fetch_en  input  1  allows new fetches when high; queued entries still drain when low.
- imem_addr  output  AW  instruction-memory address; always equals fetch_pc.
- imem_data  input  IW  instruction word; combinational from imem_addr in the same cycle.
- flush  input  1  discard the queue and redirect fetch.
- flush_pc  input  AW  new fetch PC, sampled when flush=1.
- out_valid  output  1  queue head holds a valid instruction.
- out_ready  input  1  decode accepts the head this cycle.
- out_instr  output  IW  instruction at the queue head.
- out_pc  output  AW  PC of the instruction at the queue head.
- count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- State: fetch_pc, DEPTH-entry storage of {pc, instr}, read pointer, write pointer, count.
- All state changes on the rising edge of clk; reset and flush are sampled only at the edge.
- Reset (synchronous, highest priority):
  - fetch_pc=0, pointers=0, count=0.
  - out_valid=0, out_instr=0, out_pc=0.
  - Applies identically when asserted mid-operation; all queued entries are lost.
- pop = out_valid & out_ready.
- push = fetch_en & ~flush & (count<DEPTH | pop).
  - A push is allowed when the queue is full only if a pop happens in the same cycle.
- On push:
  - Write entry {fetch_pc, imem_data}.
  - Advance the write pointer.
  - fetch_pc <= fetch_pc+1, modulo 2^AW; 15 wraps to 0 with no flag.
- On pop: advance the read pointer.
- count update:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged.
- Flush, when reset=0:
  - Takes priority over push and pop.
  - Pointers and count go to 0; fetch_pc <= flush_pc.
  - out_valid=0 in the following cycle.
  - The instruction at flush_pc is fetched in the cycle after the flush, if fetch_en=1.
  - A pop presented in the flush cycle is still counted as consumed by decode; the queue itself does not re-present that instruction.
- Outputs are registered queue state only, with no combinational path from imem_data or out_ready to out_*.
  - out_valid = (count!=0).
  - out_instr and out_pc are taken from the read-pointer entry.
  - When out_valid=0, out_instr and out_pc hold their last value (0 after reset); decode must ignore them.
- Latency: an instruction fetched in cycle N is visible at out_* in cycle N+1 if the queue was empty.
- Steady-state throughput: 1 instruction/cycle with out_ready held high.
- Handshake rules:
  - Once out_valid=1, out_instr and out_pc stay stable until a pop or flush.
  - out_valid never drops without a pop, flush or reset.
- Full: count=DEPTH with no pop → no fetch, and fetch_pc holds.
- Empty: count=0 → out_valid=0; out_ready is ignored.
- Underflow and overflow are impossible by construction.

Test Plan:
- Reset then fetch_en=1, out_ready=1, memory word[i]=i*0x111:
  - Cycle 1 after reset: out_valid=1, out_pc=0, out_instr=0x000.
  - Each following cycle: out_pc increments by 1 and out_instr steps by 0x111.
  - count stays at 1.
- Backpressure, out_ready=0 from reset:
  - count reaches 4 after 4 cycles, then holds.
  - imem_addr holds at 4; head stays pc=0.
  - Raise out_ready: pops of pc 0,1,2,3 are each immediately followed by a fresh fetch, with no gap.
- Full queue with out_ready=1 and fetch_en=1:
  - Push and pop occur in the same cycle.
  - count stays at 4 and the PC sequence stays continuous.
- Flush with flush_pc=9 while count=3:
  - Next cycle: out_valid=0, count=0.
  - Cycle after that: out_valid=1, out_pc=9, out_instr=mem[9].
- Wrap-around: run from pc 14 → out_pc sequence 14, 15, 0, 1 with correct instructions.
- Reset mid-stream with count=2 and out_ready toggling:
  - After the edge: out_valid=0, count=0, imem_addr=0.
  - Reset together with flush: reset wins, fetch_pc=0.

Source files
------------

// File: rtl/instr_fetch_queue_if.sv
// Decode-side valid/ready handshake carrying one fetched
// instruction and its PC.
interface instr_fetch_queue_if #(
  parameter int IW = 12,
  parameter int AW = 4
);
  logic          valid;
  logic          ready;
  logic [IW-1:0] instr;
  logic [AW-1:0] pc;

  modport master (
    output valid,
    output instr,
    output pc,
    input  ready
  );

  modport slave (
    input  valid,
    input  instr,
    input  pc,
    output ready
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Fetch stage: owns the fetch PC, buffers {pc, instr} in a small
// FIFO and hands the head to decode over a valid/ready handshake.
module instr_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int IW    = 12,
  parameter int AW    = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fetch_en,
  output logic [AW-1:0]              imem_addr,
  input  logic [IW-1:0]              imem_data,
  input  logic                       flush,
  input  logic [AW-1:0]              flush_pc,
  instr_fetch_queue_if.master        out,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } entry_t;

  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  entry_t        head_q, head_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  entry_t        new_ent;

  logic pop;
  logic push;

  assign pop     = (count_q != '0) & out.ready;
  assign push    = fetch_en & ~flush &
                   ((count_q < CW'(DEPTH)) | pop);
  assign new_ent = '{pc: fetch_pc_q, instr: imem_data};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    mem_d      = mem_q;
    if (flush) begin
      fetch_pc_d = flush_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = new_ent;
        wr_ptr_d        = wr_ptr_q + PW'(1);
        fetch_pc_d      = fetch_pc_q + AW'(1);
      end
      if (pop)
        rd_ptr_d = rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Head is registered so out_* never depend on imem_data or
  // out.ready combinationally; it holds while the queue is empty.
  always_comb begin
    head_d = head_q;
    if (count_d != '0) begin
      if (count_q == '0 || (pop && count_q == CW'(1)))
        head_d = new_ent;
      else
        head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      head_q     <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      head_q     <= head_d;
      mem_q      <= mem_d;
    end
  end

  assign imem_addr = fetch_pc_q;
  assign count     = count_q;
  assign out.valid = (count_q != '0);
  assign out.instr = head_q.instr;
  assign out.pc    = head_q.pc;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: directed scenarios plus random
// traffic checked against a queue-based reference model.
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;
  localparam int IW    = 12;
  localparam int AW    = 4;

  typedef logic [AW+IW-1:0] ent_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_en;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_data;
  logic          flush;
  logic [AW-1:0] flush_pc;
  logic [2:0]    count;

  logic [IW-1:0] imem [16];

  instr_fetch_queue_if #(.IW(IW), .AW(AW)) dq ();

  instr_fetch_queue #(.DEPTH(DEPTH), .IW(IW), .AW(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .fetch_en  (fetch_en),
    .imem_addr (imem_addr),
    .imem_data (imem_data),
    .flush     (flush),
    .flush_pc  (flush_pc),
    .out       (dq),
    .count     (count)
  );

  always #5 clk = ~clk;

  assign imem_data = imem[imem_addr];

  int n_chk  = 0;
  int n_fail = 0;

  ent_t          mq[$];
  int            mpc;
  logic [AW-1:0] hpc;
  logic [IW-1:0] hin;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    bit pop, push;
    if (reset) begin
      mq.delete();
      mpc = 0;
      hpc = '0;
      hin = '0;
    end else begin
      pop = (mq.size() != 0) && dq.ready;
      if (flush) begin
        mq.delete();
        mpc = int'(flush_pc);
      end else begin
        push = fetch_en && (mq.size() < DEPTH || pop);
        if (pop) void'(mq.pop_front());
        if (push) begin
          mq.push_back({AW'(mpc), imem[mpc]});
          mpc = (mpc + 1) % 16;
        end
      end
      if (mq.size() != 0) {hpc, hin} = mq[0];
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    chk("valid", 32'(dq.valid), 32'(mq.size() != 0));
    chk("count", 32'(count), 32'(mq.size()));
    chk("addr",  32'(imem_addr), 32'(mpc));
    chk("pc",    32'(dq.pc), 32'(hpc));
    chk("instr", 32'(dq.instr), 32'(hin));
  endtask

  task automatic drive(bit r, bit fe, bit rdy, bit fl,
                       logic [AW-1:0] fpc);
    reset    = r;
    fetch_en = fe;
    dq.ready = rdy;
    flush    = fl;
    flush_pc = fpc;
  endtask

  initial begin
    for (int i = 0; i < 16; i++)
      imem[i] = IW'(i * 'h111);
    mpc = 0;
    hpc = '0;
    hin = '0;
    drive(1, 0, 0, 0, '0);
    cyc();
    cyc();
    chk("rst_valid", 32'(dq.valid), 0);
    chk("rst_addr",  32'(imem_addr), 0);

    // streaming at full rate
    drive(0, 1, 1, 0, '0);
    cyc();
    chk("first_pc",    32'(dq.pc), 0);
    chk("first_instr", 32'(dq.instr), 0);
    for (int i = 1; i < 8; i++) begin
      cyc();
      chk("stream_pc",  32'(dq.pc), 32'(i));
      chk("stream_cnt", 32'(count), 1);
    end

    // backpressure then full-queue push/pop
    drive(1, 0, 0, 0, '0);
    cyc();
    drive(0, 1, 0, 0, '0);
    for (int i = 0; i < 6; i++) cyc();
    chk("bp_addr", 32'(imem_addr), 4);
    chk("bp_head", 32'(dq.pc), 0);
    chk("bp_cnt",  32'(count), 4);
    dq.ready = 1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("full_cnt", 32'(count), 4);
      chk("full_pc",  32'(dq.pc), 32'(i + 1));
    end

    // flush to 9 with three entries queued
    drive(1, 0, 0, 0, '0);
    cyc();
    drive(0, 1, 0, 0, '0);
    for (int i = 0; i < 3; i++) cyc();
    chk("pre_fl_cnt", 32'(count), 3);
    drive(0, 1, 1, 1, 4'd9);
    cyc();
    chk("fl_valid", 32'(dq.valid), 0);
    chk("fl_cnt",   32'(count), 0);
    drive(0, 1, 1, 0, '0);
    cyc();
    chk("fl_pc",    32'(dq.pc), 9);
    chk("fl_instr", 32'(dq.instr), 'h999);

    // wrap from 14
    drive(0, 1, 1, 1, 4'd14);
    cyc();
    drive(0, 1, 1, 0, '0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("wrap_pc", 32'(dq.pc), 32'((14 + i) % 16));
    end

    // reset mid-stream, then reset together with flush
    drive(0, 1, 0, 0, '0);
    cyc();
    chk("mid_cnt", 32'(count), 2);
    dq.ready = 1;
    cyc();
    drive(1, 1, 0, 0, '0);
    cyc();
    chk("mid_valid", 32'(dq.valid), 0);
    chk("mid_cnt0",  32'(count), 0);
    chk("mid_addr",  32'(imem_addr), 0);
    drive(0, 1, 1, 0, '0);
    cyc();
    cyc();
    drive(1, 1, 1, 1, 4'd5);
    cyc();
    chk("rst_fl_addr", 32'(imem_addr), 0);

    // random traffic
    for (int i = 0; i < 16; i++)
      imem[i] = IW'($urandom);
    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(99) < 2),
            ($urandom_range(99) < 80),
            ($urandom_range(1) == 1),
            ($urandom_range(99) < 6),
            AW'($urandom));
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
